// File: rtl/sparc_boot_pkg.sv
// Shared types and helpers for the SPARC program-image loader.
// Loader FSM states and width helpers.
package sparc_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    PULSE,
    RUN,
    HALT
  } boot_state_t;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/boot_watchdog.sv
// Loadable up-counter with terminal-count flag.
// Shared between the reset-pulse timer and the run watchdog.
module boot_watchdog #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] term_q;

  // load restarts from zero; counting parks at the terminal value
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      term_q <= '0;
    end else if (load) begin
      count  <= '0;
      term_q <= term;
    end else if (en && count != term_q) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == term_q);

endmodule

// File: rtl/boot_loader.sv
// Streams an image big-endian into byte RAM, then pulses
// core reset and runs a watchdog until timeout.
module boot_loader
  import sparc_boot_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int BASE_ADDR  = 0,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 100000
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_reset,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam int BYTES   = bytes_of(DATA_W);
  localparam int BC_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_MAX = max_of(RST_CYCLES, TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PULSE_TC = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_TC   = CNT_W'(TIMEOUT - 1);
  localparam logic [BC_W-1:0]  LAST_B   = BC_W'(BYTES - 1);

  localparam logic [ADDR_W:0] MEM_SZ  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] BYTES_W = (ADDR_W+1)'(BYTES);
  localparam logic [ADDR_W:0] BASE    = (ADDR_W+1)'(BASE_ADDR);

  boot_state_t       state;
  logic [ADDR_W:0]   ptr;
  logic [DATA_W-1:0] shreg;
  logic [BC_W-1:0]   bcnt;
  logic              last_q;

  logic              fits;
  logic              accept;
  logic              byte_end;
  logic              wd_load;
  logic              wd_en;
  logic              wd_tc;
  logic [CNT_W-1:0]  wd_term;

  // ptr carries one extra bit so a full RAM never wraps to zero
  assign fits     = (ptr + BYTES_W) <= MEM_SZ;
  assign accept   = in_valid && in_ready;
  assign byte_end = (state == WRITE) && (bcnt == LAST_B);
  assign mem_addr = ptr[ADDR_W] ? {ADDR_W{1'b1}}
                                : ptr[ADDR_W-1:0];

  assign wd_load = (byte_end && last_q)
                || (state == PULSE && wd_tc);
  assign wd_en   = (state == PULSE) || (state == RUN);
  assign wd_term = (state == WRITE) ? PULSE_TC : RUN_TC;

  boot_watchdog #(
    .CNT_W(CNT_W)
  ) u_wd (
    .clk (Clk),
    .rst (RESET),
    .load(wd_load),
    .en  (wd_en),
    .term(wd_term),
    .tc  (wd_tc)
  );

  // loader FSM with registered outputs
  always_ff @(posedge Clk) begin
    if (RESET) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_data     <= '0;
      cpu_reset    <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      ptr          <= BASE;
      shreg        <= '0;
      bcnt         <= '0;
      last_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cpu_reset <= 1'b1;
          if (accept) begin
            in_ready <= 1'b0;
            if (!fits) begin
              error <= 1'b1;
              state <= HALT;
            end else begin
              mem_we   <= 1'b1;
              mem_data <= in_data[DATA_W-1 -: 8];
              shreg    <= in_data << 8;
              last_q   <= in_last;
              bcnt     <= '0;
              if (words_loaded != {ADDR_W{1'b1}})
                words_loaded <= words_loaded + ADDR_W'(1);
              state    <= WRITE;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        WRITE: begin
          ptr <= ptr + (ADDR_W+1)'(1);
          if (bcnt == LAST_B) begin
            mem_we <= 1'b0;
            if (last_q) begin
              state <= PULSE;
            end else begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            bcnt     <= bcnt + BC_W'(1);
            mem_data <= shreg[DATA_W-1 -: 8];
            shreg    <= shreg << 8;
          end
        end
        PULSE: begin
          if (wd_tc) begin
            cpu_reset <= 1'b0;
            running   <= 1'b1;
            done      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (wd_tc) begin
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            timeout   <= 1'b1;
            state     <= HALT;
          end
        end
        HALT: begin
          in_ready  <= 1'b0;
          cpu_reset <= 1'b1;
          running   <= 1'b0;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Synthesizable program-image loader for the SPARC core. Accepts a stream of instruction/data words, writes each word into the byte-addressed RAM big-endian (MSB byte at lowest address), and holds the core in reset until the image is complete. It then issues a reset pulse of programmable length and runs a cycle watchdog that flags a timeout. It replaces the bench-side file-load, reset-pulse and finish-timer sequence with a parametrised block usable in simulation and on hardware.

## Interface
Parameters:
- DATA_W, 32, word width in bits; multiple of 8, ≥ 8; BYTES = DATA_W/8
- ADDR_W, 9, RAM byte-address width (512 bytes)
- BASE_ADDR, 0, first byte address written; must be BYTES-aligned
- RST_CYCLES, 2, cycles cpu_reset stays high after the last byte is written (≥ 1)
- TIMEOUT, 100000, RUN cycles before timeout is raised (≥ 1)

Ports:
- Clk  in  1  clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- in_valid  in  1  word on in_data is valid
- in_data  in  DATA_W  image word
- in_last  in  1  qualifies in_data as the final word of the image
- in_ready  out  1  block accepts a word this cycle
- mem_we  out  1  RAM byte write strobe
- mem_addr  out  ADDR_W  RAM byte address
- mem_data  out  8  RAM byte data
- cpu_reset  out  1  reset to ControlUnit/DataPath, active-high
- running  out  1  core released, watchdog counting
- done  out  1  image loaded and core released (sticky until RESET)
- timeout  out  1  watchdog expired (sticky)
- error  out  1  image overflowed RAM (sticky)
- words_loaded  out  ADDR_W  count of accepted words, saturating

## Operation
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_data=0, cpu_reset=1, running=0, done=0, timeout=0, error=0, words_loaded=0; state IDLE.
- States: IDLE, WRITE, PULSE, RUN, HALT.
- IDLE: in_ready=1, cpu_reset=1. On in_valid: if mem_addr+BYTES > 2^ADDR_W, word is rejected and not written, error=1 → HALT; otherwise latch in_data and in_last, words_loaded+1 → WRITE.
- WRITE: BYTES cycles, one byte per cycle, mem_we=1; byte k (k=0 first) = word[DATA_W-1-8k -: 8] at mem_addr, mem_addr+1 after each byte. After the last byte: latched in_last → PULSE, else → IDLE.
- PULSE: cpu_reset=1 for exactly RST_CYCLES cycles → RUN.
- RUN: cpu_reset=0, running=1, done=1; the watchdog counts up from 0. When the count reaches TIMEOUT-1: timeout=1 → HALT.
- HALT: cpu_reset=1, running=0, in_ready=0; leaves only via RESET. done keeps its value.
- Address arithmetic is ADDR_W-bit. The overflow check uses an ADDR_W+1-bit sum, so a word that exactly fills the last byte is legal. mem_addr never wraps.
- in_valid with in_ready=0 is ignored (no skid buffer); in_data may change freely while in_ready=0.

## Timing
- Handshake: transfer when in_valid && in_ready, sampled at the rising edge. in_ready is 1 only in IDLE.
- Word accepted at edge t. Bytes are written on cycles t+1 … t+BYTES. in_ready returns at cycle t+BYTES+1. Throughput is 1 word per BYTES+1 cycles.
- Last word accepted at t: cpu_reset is high through cycle t+BYTES+RST_CYCLES, falls on cycle t+BYTES+RST_CYCLES+1, and running/done rise on the same cycle.
- timeout rises on the TIMEOUT-th RUN cycle. cpu_reset goes high on the same cycle.
- RESET asserted in any state, including mid-WRITE: all outputs return to reset values on the next edge. A partially written word remains in RAM, and the next word rewrites from BASE_ADDR.
- If in_valid and the overflow condition are both present in IDLE, error wins and there is no write cycle.

## Structure
- Shared package sparc_boot_pkg: state enum (IDLE, WRITE, PULSE, RUN, HALT) and the BYTES localparam function.
- One natural sub-module: boot_watchdog (a loadable up-counter with terminal-count output). It is reused for the PULSE length and the RUN timeout.
- The RAM stays in DataPath; the top-level muxes the RAM port between boot_loader (while cpu_reset=1) and the core.

## Test plan
- Defaults, 3 words 0x8210_0005, 0x8400_6003, 0x0100_0000 (last on third) → bytes 82 10 00 05 84 00 60 03 01 00 00 00 at addresses 0–11; words_loaded=3; cpu_reset falls 2 cycles after the address-11 write; done=1.
- in_valid held high with back-to-back words → in_ready pattern is 1 followed by 4 zeros, repeating; no word is lost or duplicated.
- ADDR_W=4, DATA_W=32, 5 words → first 4 are written (addresses 0–15); on the 5th, error=1, HALT, no mem_we, cpu_reset stays 1.
- TIMEOUT=10, single last word → running high for exactly 10 cycles, then timeout=1, cpu_reset=1, state HALT.
- RESET asserted on the 2nd byte of word 1 → next edge: mem_addr=0, mem_we=0, words_loaded=0, cpu_reset=1; a reloaded image overwrites from address 0.
- DATA_W=16, BASE_ADDR=8, 2 words 0xABCD, 0x1234 → AB CD 12 34 written at addresses 8–11; each word takes 3 cycles.
